uart_ctrl: RTL and testbench
============================

UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 250, giving system clocks per serial bit (40 MHz / 160 kbaud); legal range 4..65535.
REQ-002 SHALL provide parameter RX_FIFO_DEPTH, default 4, giving receive FIFO entries; power of two, minimum 2.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 rx  input  1  asynchronous serial input, idle high.
REQ-006 tx  output  1  serial output, idle high, registered.
REQ-007 tx_data  input  8  byte to transmit.
REQ-008 tx_valid  input  1  tx_data valid.
REQ-009 tx_ready  output  1  transmitter can accept a byte.
REQ-010 rx_data  output  8  head byte of receive FIFO.
REQ-011 rx_valid  output  1  receive FIFO non-empty.
REQ-012 rx_ready  input  1  consumer pops head byte.
REQ-013 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-014 overrun  output  1  one-cycle pulse: received byte dropped because the FIFO was full.

Function
REQ-015 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity; each bit CLKS_PER_BIT cycles.
REQ-016 TX FSM SHALL have states T_IDLE, T_START, T_DATA, T_STOP; tx_ready = 1 only in T_IDLE.
REQ-017 A handshake SHALL occur on a rising edge with tx_valid=1 and tx_ready=1; tx_data is latched on that edge and the FSM enters T_START.
REQ-018 tx SHALL be 0 for CLKS_PER_BIT cycles in T_START, carry bit i for CLKS_PER_BIT cycles in T_DATA (i=0..7), then be 1 for CLKS_PER_BIT cycles in T_STOP.
REQ-019 tx_ready SHALL reassert exactly 10*CLKS_PER_BIT cycles after the handshake edge; tx_data/tx_valid changes during a frame SHALL be ignored.
REQ-020 rx SHALL pass through a 2-flop synchronizer (rx_s); all RX decisions use rx_s only.
REQ-021 RX FSM SHALL have states R_IDLE, R_START, R_DATA, R_STOP, R_BREAK, with a bit counter (0..CLKS_PER_BIT-1) and a 3-bit data index.
REQ-022 R_IDLE -> R_START when rx_s=0; counter cleared.
REQ-023 R_START SHALL sample rx_s at count CLKS_PER_BIT/2-1 (mid-bit): if 1, return to R_IDLE (glitch; no flags); if 0, go to R_DATA.
REQ-024 R_DATA SHALL sample every CLKS_PER_BIT cycles at mid-bit, shift {rx_s, shreg[7:1]}, and go to R_STOP after the 8th sample.
REQ-025 R_STOP mid-bit sample = 1 SHALL push shreg into the FIFO and return to R_IDLE on the same edge, so the next start bit can be detected.
REQ-026 R_STOP mid-bit sample = 0 SHALL pulse frame_err, discard the byte, and enter R_BREAK; R_BREAK -> R_IDLE when rx_s=1.
REQ-027 The FIFO SHALL be show-ahead: rx_valid = count != 0, rx_data = head entry; a pop occurs on a rising edge with rx_valid=1 and rx_ready=1.
REQ-028 A push when full SHALL pulse overrun and leave the FIFO contents unchanged, except when a pop occurs on the same edge, in which case the push succeeds and overrun stays 0.
REQ-029 rx_ready=1 with rx_valid=0 SHALL have no effect; the pointers wrap modulo RX_FIFO_DEPTH; count width is clog2(RX_FIFO_DEPTH)+1.
REQ-030 TX and RX SHALL operate fully independently and concurrently.

Reset
REQ-031 While rst_n=0 at a rising edge: both FSMs go idle, the FIFO empties, tx=1, rx_valid=0, frame_err=0, overrun=0, the synchronizer is loaded with 1; handshakes are ignored.
REQ-032 tx_ready SHALL be 0 while rst_n=0 and 1 from the first cycle after release.
REQ-033 Reset mid-frame SHALL abort the frame: tx=1 after the next edge, any partial RX byte discarded, no flag pulses.

Verification
REQ-034 tx_data=0xA5 handshake at edge E -> tx low for 250 cycles, then bits 1,0,1,0,0,1,0,1, then high; tx_ready=1 at E+2500.
REQ-035 rx driven with 0x3C at 250 cycles/bit -> rx_valid rises within 9.5*250+3 cycles of the start edge, rx_data=0x3C, frame_err=0.
REQ-036 rx low for 100 cycles then high -> no rx_valid, no frame_err; a following 0x81 frame is received correctly.
REQ-037 0x55 with stop bit low, line then held low for 500 cycles -> one frame_err pulse, FIFO empty; the next valid 0x12 frame after the line returns high is received.
REQ-038 Five frames 0x01..0x05 with rx_ready=0 -> overrun pulse on the 5th; draining yields 0x01..0x04 in order; a simultaneous pop and push at full yields no overrun.
REQ-039 Loopback (tx tied to rx) with 0x00 and 0xFF, plus rst_n pulsed mid-TX-frame -> bytes received intact; after reset tx=1, tx_ready=1, rx_valid=0.

Source files
------------

// File: rtl/uart_ctrl.sv
// uart_ctrl: 8N1 UART transmitter and receiver with a show-ahead receive FIFO.
//
// Ports
//   clk        in   system clock; all state changes on its rising edge
//   rst_n      in   synchronous active-low reset
//   rx         in   asynchronous serial input, idle high
//   tx         out  serial output, idle high, registered
//   tx_data    in   byte to transmit
//   tx_valid   in   tx_data valid
//   tx_ready   out  transmitter idle and able to accept a byte
//   rx_data    out  head byte of the receive FIFO
//   rx_valid   out  receive FIFO non-empty
//   rx_ready   in   consumer pops the head byte
//   frame_err  out  one-cycle pulse: stop bit sampled low
//   overrun    out  one-cycle pulse: received byte dropped, FIFO full
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1 (tx_valid/tx_ready for transmit, rx_valid/rx_ready for the FIFO
// pop). Valid may be asserted independently of ready; ready=1 with valid=0
// has no effect.
//
// TX and RX FSM states are visible as r_tx_state / r_rx_state.

module uart_ctrl #(
  parameter int unsigned CLKS_PER_BIT  = 250,
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned AW = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] BIT_MID  = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(RX_FIFO_DEPTH);

  // ---------------------------------------------------------------- TX ---
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

  tx_state_t   r_tx_state;
  tx_state_t   w_tx_state_nxt;
  logic [15:0] r_tx_cnt;
  logic [2:0]  r_tx_idx;
  logic [2:0]  w_tx_idx_nxt;
  logic [7:0]  r_tx_shreg;
  logic        r_tx;
  logic        w_tx_d;
  logic        w_tx_bit_done;
  logic        w_tx_hs;

  assign w_tx_bit_done = (r_tx_cnt == BIT_LAST);
  assign w_tx_hs       = (r_tx_state == T_IDLE) && tx_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) r_tx_state <= T_IDLE;
    else        r_tx_state <= w_tx_state_nxt;
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_idx_nxt   = r_tx_idx;
    case (r_tx_state)
      T_IDLE:  if (tx_valid) w_tx_state_nxt = T_START;
      T_START: begin
        w_tx_idx_nxt = 3'd0;
        if (w_tx_bit_done) w_tx_state_nxt = T_DATA;
      end
      T_DATA: if (w_tx_bit_done) begin
        w_tx_idx_nxt = r_tx_idx + 3'd1;
        if (r_tx_idx == 3'd7) w_tx_state_nxt = T_STOP;
      end
      T_STOP:  if (w_tx_bit_done) w_tx_state_nxt = T_IDLE;
      default: w_tx_state_nxt = T_IDLE;
    endcase
  end

  // The line level is decoded from the next state so the registered tx
  // changes on the same edge as the state does.
  always_comb begin
    w_tx_d = 1'b1;
    case (w_tx_state_nxt)
      T_START: w_tx_d = 1'b0;
      T_DATA:  w_tx_d = r_tx_shreg[w_tx_idx_nxt];
      default: w_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx       <= 1'b1;
      r_tx_cnt   <= 16'd0;
      r_tx_idx   <= 3'd0;
      r_tx_shreg <= 8'd0;
    end else begin
      r_tx     <= w_tx_d;
      r_tx_idx <= w_tx_idx_nxt;
      if (r_tx_state == T_IDLE || w_tx_bit_done) r_tx_cnt <= 16'd0;
      else                                       r_tx_cnt <= r_tx_cnt + 16'd1;
      if (w_tx_hs) r_tx_shreg <= tx_data;
    end
  end

  assign tx       = r_tx;
  // Gated by rst_n so no handshake can be offered while reset is held.
  assign tx_ready = rst_n && (r_tx_state == T_IDLE);

  // ---------------------------------------------------------------- RX ---
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;

  rx_state_t   r_rx_state;
  rx_state_t   w_rx_state_nxt;
  logic        r_rx_s1;
  logic        r_rx_s2;
  logic        w_rx_s;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_idx;
  logic [7:0]  r_rx_shreg;
  logic        w_rx_mid;
  logic        w_rx_bit_done;
  logic        w_rx_sample;
  logic        w_rx_push;
  logic        w_frame_err_d;
  logic        r_frame_err;

  assign w_rx_s        = r_rx_s2;
  assign w_rx_mid      = (r_rx_cnt == BIT_MID);
  assign w_rx_bit_done = (r_rx_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_rx_state <= R_IDLE;
    else        r_rx_state <= w_rx_state_nxt;
  end

  // After the start-bit mid-sample the counter restarts, so every later
  // full-bit wrap lands in the middle of a data or stop bit.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    case (r_rx_state)
      R_IDLE:  if (!w_rx_s) w_rx_state_nxt = R_START;
      R_START: if (w_rx_mid) w_rx_state_nxt = w_rx_s ? R_IDLE : R_DATA;
      R_DATA:  if (w_rx_bit_done && r_rx_idx == 3'd7) w_rx_state_nxt = R_STOP;
      R_STOP:  if (w_rx_bit_done) w_rx_state_nxt = w_rx_s ? R_IDLE : R_BREAK;
      R_BREAK: if (w_rx_s) w_rx_state_nxt = R_IDLE;
      default: w_rx_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_rx_sample   = (r_rx_state == R_DATA) && w_rx_bit_done;
    w_rx_push     = (r_rx_state == R_STOP) && w_rx_bit_done && w_rx_s;
    w_frame_err_d = (r_rx_state == R_STOP) && w_rx_bit_done && !w_rx_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_cnt    <= 16'd0;
      r_rx_idx    <= 3'd0;
      r_rx_shreg  <= 8'd0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err_d;
      if (r_rx_state == R_IDLE || r_rx_state == R_BREAK ||
          (r_rx_state == R_START && w_rx_mid) || w_rx_bit_done)
        r_rx_cnt <= 16'd0;
      else
        r_rx_cnt <= r_rx_cnt + 16'd1;
      if (r_rx_state == R_IDLE) r_rx_idx <= 3'd0;
      else if (w_rx_sample)     r_rx_idx <= r_rx_idx + 3'd1;
      if (w_rx_sample) r_rx_shreg <= {w_rx_s, r_rx_shreg[7:1]};
    end
  end

  assign frame_err = r_frame_err;

  // ------------------------------------------------------- RX FIFO -------
  logic [7:0]    r_mem [RX_FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overrun;
  logic          w_full;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_overrun_d;

  assign w_full      = (r_count == FIFO_FULL);
  assign w_pop       = rx_ready && (r_count != '0);
  // A pop on the same edge frees the slot, so a push at full still lands.
  assign w_push_ok   = w_rx_push && (!w_full || w_pop);
  assign w_overrun_d = w_rx_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst_n && w_push_ok) r_mem[r_wr_ptr] <= r_rx_shreg;
  end

  // Pointers are exactly log2(depth) bits, so they wrap on their own.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_overrun_d;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rx_data  = r_mem[r_rd_ptr];
  assign rx_valid = (r_count != '0);
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed-plus-random bench for uart_ctrl. Expected receive
// bytes live in exp_q (an ideal bounded FIFO); expected tx waveforms are
// computed from the frame format with plain arithmetic.

module tb_uart_ctrl;
  localparam int C     = 250;
  localparam int DEPTH = 4;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       tb_rx    = 1'b1;
  logic       loop_en  = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       rx_ready = 1'b0;
  logic       rx_pin;
  logic       tx;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  assign rx_pin = loop_en ? tx : tb_rx;

  uart_ctrl #(.CLKS_PER_BIT(C), .RX_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx_pin), .tx(tx),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun)
  );

  // ---------------------------------------------- clock / cycle count ---
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog cycles=%0d limit=95000", cyc);
    $fatal(1, "bench timeout");
  end

  // ------------------------------------------------ pulse monitors ------
  int   fe_cnt   = 0;
  int   ov_cnt   = 0;
  int   rise_cyc = 0;
  logic prev_v   = 1'b0;

  always @(negedge clk) begin
    fe_cnt <= fe_cnt + (frame_err === 1'b1 ? 1 : 0);
    ov_cnt <= ov_cnt + (overrun === 1'b1 ? 1 : 0);
    if (rx_valid === 1'b1 && prev_v === 1'b0) rise_cyc <= cyc;
    prev_v <= rx_valid;
  end

  // ---------------------------------------------------- scoreboard ------
  int         n_checks = 0;
  int         n_fail   = 0;
  int         exp_ov   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_range(input string tag, input int val, input int lo, input int hi);
    n_checks++;
    assert (val >= lo && val <= hi) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, val, lo, hi);
    end
  endtask

  // Ideal receiver: a completed frame enters the queue unless it is full.
  task automatic model_rx(input logic [7:0] b);
    if (exp_q.size() >= DEPTH) exp_ov++;
    else exp_q.push_back(b);
  endtask

  // ------------------------------------------------------- drivers ------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_v);
    tb_rx = 1'b0;
    step(C);
    for (int i = 0; i < 8; i++) begin
      tb_rx = b[i];
      step(C);
    end
    tb_rx = stop_v;
    step(C);
  endtask

  task automatic send_good(input logic [7:0] b);
    drive_frame(b, 1'b1);
    model_rx(b);
    step($urandom_range(0, 20));
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    check({tag, "_valid"}, rx_valid, 1);
    check({tag, "_data"}, rx_data, e);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    while (exp_q.size() > 0) pop_check(tag);
    check({tag, "_empty"}, rx_valid, 0);
  endtask

  task automatic wait_tx_ready(input string tag);
    int k;
    k = 0;
    while (tx_ready !== 1'b1 && k < 12 * C) begin
      step(1);
      k++;
    end
    check(tag, tx_ready, 1);
  endtask

  task automatic tx_send(input logic [7:0] b);
    wait_tx_ready("tx_ready_pre");
    tx_data  = b;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    wait_tx_ready("tx_ready_post");
  endtask

  // Walks a whole frame cycle by cycle with tx_valid held high and the
  // data bus changed, checking the first and last cycle of every bit.
  task automatic tx_frame_check(input logic [7:0] b);
    logic exp_b;
    check("tx_ready_pre", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    step(1);
    tx_data = ~b;
    for (int k = 0; k < 10 * C; k++) begin
      if (k < C)          exp_b = 1'b0;
      else if (k < 9 * C) exp_b = b[3'((k - C) / C)];
      else                exp_b = 1'b1;
      if (k % C == 0 || k % C == C - 1) check("tx_bit", tx, exp_b);
      if (k == 0 || k == 10 * C - 1)    check("tx_ready_busy", tx_ready, 0);
      if (k == 10 * C - 1) tx_valid = 1'b0;
      step(1);
    end
    check("tx_ready_back", tx_ready, 1);
    check("tx_idle", tx, 1);
  endtask

  // ------------------------------------------------------- sequence -----
  initial begin
    int         c0;
    int         fe0;
    int         ov0;
    logic [7:0] b;

    // Reset values.
    rst_n = 1'b0;
    step(3);
    check("rst_tx", tx, 1);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    step(1);
    check("rel_tx_ready", tx_ready, 1);
    check("rel_tx", tx, 1);

    // Transmit waveform: fixed pattern then a random byte.
    tx_frame_check(8'hA5);
    tx_frame_check(8'($urandom_range(0, 255)));

    // Receive 0x3C with latency bound from the edge that first sees the start bit.
    fe0 = fe_cnt;
    c0  = cyc;
    drive_frame(8'h3C, 1'b1);
    model_rx(8'h3C);
    check_range("rx_latency", rise_cyc - (c0 + 1), 9 * C, 9 * C + C / 2 + 3);
    check("rx_3c_ferr", fe_cnt - fe0, 0);
    drain_check("rx_3c");

    // Short low glitch: ignored, then a normal frame.
    tb_rx = 1'b0;
    step(100);
    tb_rx = 1'b1;
    step(2 * C);
    check("glitch_valid", rx_valid, 0);
    check("glitch_ferr", fe_cnt - fe0, 0);
    send_good(8'h81);
    drain_check("rx_81");

    // Bad stop bit, line held low, recovery.
    fe0 = fe_cnt;
    drive_frame(8'h55, 1'b0);
    step(500);
    check("ferr_pulse", fe_cnt - fe0, 1);
    check("ferr_empty", rx_valid, 0);
    tb_rx = 1'b1;
    step(C);
    send_good(8'h12);
    drain_check("rx_12");
    check("ferr_once", fe_cnt - fe0, 1);

    // Overrun on the fifth frame with nobody popping.
    ov0    = ov_cnt;
    exp_ov = 0;
    for (int i = 1; i <= 5; i++) begin
      send_good(8'(i));
      check("ovr_count", ov_cnt - ov0, exp_ov);
    end
    drain_check("ovr_drain");

    // Full FIFO, then a pop on exactly the edge the fifth byte is pushed.
    ov0    = ov_cnt;
    exp_ov = 0;
    for (int i = 0; i < DEPTH; i++) send_good(8'($urandom_range(0, 255)));
    b = 8'($urandom_range(0, 255));
    fork
      drive_frame(b, 1'b1);
      begin
        step(9 * C + C / 2 + 2);
        check("simul_head", rx_data, exp_q[0]);
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        void'(exp_q.pop_front());
      end
    join
    model_rx(b);
    check("simul_ovr", ov_cnt - ov0, exp_ov);
    drain_check("simul_drain");

    // Pop attempts on an empty FIFO change nothing.
    rx_ready = 1'b1;
    step(5);
    rx_ready = 1'b0;
    check("empty_pop", rx_valid, 0);
    send_good(8'($urandom_range(0, 255)));
    drain_check("after_empty_pop");

    // Loopback.
    loop_en = 1'b1;
    step(2);
    for (int i = 0; i < 4; i++) begin
      b = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'($urandom_range(0, 255));
      tx_send(b);
      model_rx(b);
      drain_check("loop");
    end

    // Reset in the middle of a loopback frame.
    tx_data  = 8'($urandom_range(0, 255));
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    step(4 * C + $urandom_range(0, C));
    rst_n = 1'b0;
    step(1);
    check("mid_rst_tx", tx, 1);
    check("mid_rst_tx_ready", tx_ready, 0);
    check("mid_rst_rx_valid", rx_valid, 0);
    step(2);
    rst_n = 1'b1;
    exp_q.delete();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    step(1);
    check("post_rst_tx", tx, 1);
    check("post_rst_tx_ready", tx_ready, 1);
    check("post_rst_rx_valid", rx_valid, 0);
    step(12 * C);
    check("post_rst_quiet", rx_valid, 0);
    check("post_rst_ferr", fe_cnt - fe0, 0);
    check("post_rst_ovr", ov_cnt - ov0, 0);
    b = 8'($urandom_range(0, 255));
    tx_send(b);
    model_rx(b);
    drain_check("post_rst_loop");
    loop_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
